handshake_upsizer: RTL

Width-upsizing stage that sits directly downstream of an 8-bit `handshake_master` and packs RATIO narrow valid/ready beats into one wide beat for a 32-bit consumer such as `handshake_slave`. A `s_last` marker lets a partial word be flushed early with a byte-lane keep mask. Output is fully registered. Sustains one narrow beat per cycle while the downstream stage keeps `m_ready` high.

---
 rtl/handshake_upsizer.sv | 84 ++++++++
 1 files changed

// File: rtl/handshake_upsizer.sv
// Packs RATIO narrow valid/ready beats into one registered wide word.
// s_last closes a partial word early; unwritten lanes are zero with keep cleared.
module handshake_upsizer #(
    parameter int IN_BITS = 8,
    parameter int RATIO   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_BITS-1:0]         s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [IN_BITS*RATIO-1:0]   m_data,
    output logic [RATIO-1:0]           m_keep,
    output logic                       m_last
);

    localparam int              CW      = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int              OW      = IN_BITS * RATIO;
    localparam logic [CW-1:0]   CNT_MAX = CW'(RATIO - 1);

    logic [CW-1:0]    cnt;
    logic [OW-1:0]    acc;
    logic [OW-1:0]    acc_w;
    logic [RATIO-1:0] keep;
    logic [RATIO-1:0] keep_w;
    logic             accept;
    logic             complete;
    logic             drain;

    // Held low in reset so upstream never sees a ready during reset.
    assign s_ready  = rst && (!m_valid || m_ready);
    assign accept   = s_valid && s_ready;
    assign complete = accept && ((cnt == CNT_MAX) || s_last);
    assign drain    = m_valid && m_ready;

    // Accumulator view including the beat being accepted this cycle.
    always_comb begin
        acc_w  = acc;
        keep_w = keep;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt == CW'(i)) begin
                acc_w[i*IN_BITS +: IN_BITS] = s_data;
                keep_w[i]                   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            keep <= '0;
            cnt  <= '0;
        end else if (complete) begin
            acc  <= '0;
            keep <= '0;
            cnt  <= '0;
        end else if (accept) begin
            acc  <= acc_w;
            keep <= keep_w;
            cnt  <= cnt + CW'(1);
        end
    end

    // Reload on a completing beat wins over a drain, giving back-to-back words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (complete) begin
            m_valid <= 1'b1;
            m_data  <= acc_w;
            m_keep  <= keep_w;
            m_last  <= s_last;
        end else if (drain) begin
            m_valid <= 1'b0;
        end
    end

endmodule
